// File: rtl/bp_be_pkg.sv
// Shared back-end definitions: store-queue entry layout, dcache size aliases
// and byte-lane helpers used by the store queue and its forwarding network.
package bp_be_pkg;

    localparam int sq_paddr_max_w = 64;

    // Same encoding as the dcache op size field
    typedef enum logic [1:0] {
        e_sq_size_b = 2'd0,
        e_sq_size_h = 2'd1,
        e_sq_size_w = 2'd2,
        e_sq_size_d = 2'd3
    } bp_be_sq_size_e;

    // paddr is kept dword-aligned; the byte offset is recovered from mask
    typedef struct packed {
        logic [sq_paddr_max_w-1:0] paddr;
        bp_be_sq_size_e            size;
        logic [7:0]                mask;
        logic [63:0]               data;
    } bp_be_sq_entry_s;

    function automatic logic [7:0] sq_byte_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic [63:0] sq_data_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] sq_align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    // Byte offset of an entry = position of its lowest mask bit
    function automatic logic [2:0] sq_mask_off(input logic [7:0] mask);
        logic [2:0] off;
        off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) off = 3'(i);
        end
        return off;
    endfunction

endpackage

// File: rtl/bp_be_sq_fwd.sv
// Combinational store-to-load forwarding network. Walks the queue from the
// oldest entry to the youngest so later (younger) matches override earlier
// ones per byte lane.
module bp_be_sq_fwd
    import bp_be_pkg::*;
#(
    parameter int els_p = 8,
    localparam int idx_w_lp = $clog2(els_p)
)(
    input  bp_be_sq_entry_s [els_p-1:0] entries_i,
    input  logic [els_p-1:0]            valid_i,
    input  logic [idx_w_lp-1:0]         rd_idx_i,
    input  logic [sq_paddr_max_w-1:0]   ld_paddr_i,
    input  logic [7:0]                  ld_mask_i,
    output logic [63:0]                 data_o,
    output logic [7:0]                  covered_o
);

    logic [idx_w_lp-1:0] idx;
    logic                unused_fwd;

    assign unused_fwd = ^{entries_i, ld_paddr_i[2:0]};

    // Oldest-to-youngest scan; the last writer of a lane is the youngest match
    always_comb begin
        data_o    = '0;
        covered_o = '0;
        idx       = '0;
        for (int k = 0; k < els_p; k++) begin
            idx = rd_idx_i + idx_w_lp'(k);
            if (valid_i[idx] && (entries_i[idx].paddr[sq_paddr_max_w-1:3] == ld_paddr_i[sq_paddr_max_w-1:3])) begin
                for (int b = 0; b < 8; b++) begin
                    if (entries_i[idx].mask[b] && ld_mask_i[b]) begin
                        data_o[8*b +: 8] = entries_i[idx].data[8*b +: 8];
                        covered_o[b]     = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/bp_be_pipe_mem_sq.sv
// Committed-store queue: buffers committed stores, drains them in order to the
// D$ write port and forwards byte data to younger loads one cycle after probe.
module bp_be_pipe_mem_sq
    import bp_be_pkg::*;
#(
    parameter int els_p         = 8,
    parameter int paddr_width_p = 40,
    parameter int fwd_en_p      = 1,
    localparam int idx_w_lp     = $clog2(els_p),
    localparam int ptr_w_lp     = idx_w_lp + 1
)(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enq_v_i,
    output logic                     enq_ready_o,
    input  logic [paddr_width_p-1:0] enq_paddr_i,
    input  logic [1:0]               enq_size_i,
    input  logic [63:0]              enq_data_i,
    output logic                     deq_v_o,
    input  logic                     deq_yumi_i,
    output logic [paddr_width_p-1:0] deq_paddr_o,
    output logic [1:0]               deq_size_o,
    output logic [63:0]              deq_data_o,
    input  logic                     ld_v_i,
    input  logic [paddr_width_p-1:0] ld_paddr_i,
    input  logic [1:0]               ld_size_i,
    output logic                     ld_v_o,
    output logic                     ld_hit_o,
    output logic                     ld_partial_o,
    output logic [63:0]              ld_data_o,
    output logic                     empty_o,
    output logic [ptr_w_lp-1:0]      count_o
);

    logic [ptr_w_lp-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [els_p-1:0]            valid_q, valid_d;
    bp_be_sq_entry_s [els_p-1:0] mem_q;

    logic [idx_w_lp-1:0] wr_idx, rd_idx;
    logic                full, empty, enq_fire, deq_fire;

    assign wr_idx   = wptr_q[idx_w_lp-1:0];
    assign rd_idx   = rptr_q[idx_w_lp-1:0];
    assign full     = (wr_idx == rd_idx) && (wptr_q[idx_w_lp] != rptr_q[idx_w_lp]);
    assign empty    = (wptr_q == rptr_q);
    // No enqueue while full, even if the head drains this cycle
    assign enq_fire = enq_v_i & ~full;
    assign deq_fire = deq_yumi_i & ~empty;

    assign enq_ready_o = ~full;
    assign deq_v_o     = ~empty;
    assign empty_o     = empty;
    assign count_o     = wptr_q - rptr_q;

    // Enqueue entry: dword-aligned address, lane mask, lane-aligned data
    logic [sq_paddr_max_w-1:0] enq_paddr_ext;
    bp_be_sq_entry_s           enq_entry;

    assign enq_paddr_ext = sq_paddr_max_w'(enq_paddr_i);

    always_comb begin
        enq_entry.paddr = {enq_paddr_ext[sq_paddr_max_w-1:3], 3'b000};
        enq_entry.size  = bp_be_sq_size_e'(enq_size_i);
        enq_entry.mask  = sq_byte_mask(enq_size_i, enq_paddr_i[2:0]);
        enq_entry.data  = (enq_data_i & sq_data_mask(enq_size_i)) << {enq_paddr_i[2:0], 3'b000};
    end

    // Pointer and valid-bit next state
    always_comb begin
        wptr_d  = wptr_q + ptr_w_lp'(enq_fire);
        rptr_d  = rptr_q + ptr_w_lp'(deq_fire);
        valid_d = valid_q;
        if (deq_fire) valid_d[rd_idx] = 1'b0;
        if (enq_fire) valid_d[wr_idx] = 1'b1;
    end

    // Queue control state; reset discards everything in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; contents are qualified by valid_q
    always_ff @(posedge clk_i) begin
        if (enq_fire) mem_q[wr_idx] <= enq_entry;
    end

    // Head entry back to right-justified D$ form
    bp_be_sq_entry_s           head;
    logic [2:0]                head_off;
    logic [sq_paddr_max_w-1:0] head_paddr;
    logic                      unused_head;

    assign head        = mem_q[rd_idx];
    assign head_off    = sq_mask_off(head.mask);
    assign head_paddr  = {head.paddr[sq_paddr_max_w-1:3], head_off};
    assign deq_paddr_o = head_paddr[paddr_width_p-1:0];
    assign deq_size_o  = head.size;
    assign deq_data_o  = head.data >> {head_off, 3'b000};
    assign unused_head = ^{head.paddr[2:0], head_paddr};

    // Probe stage: snapshot of the current entries (same-cycle enqueue unseen)
    logic [7:0]  ld_mask, fwd_covered;
    logic [63:0] fwd_data;
    logic        hit_c, partial_c;

    assign ld_mask = sq_byte_mask(ld_size_i, ld_paddr_i[2:0]);

    bp_be_sq_fwd #(.els_p(els_p)) fwd (
        .entries_i (mem_q),
        .valid_i   (valid_q),
        .rd_idx_i  (rd_idx),
        .ld_paddr_i(sq_paddr_max_w'(ld_paddr_i)),
        .ld_mask_i (ld_mask),
        .data_o    (fwd_data),
        .covered_o (fwd_covered)
    );

    assign hit_c     = (fwd_en_p != 0) && (fwd_covered == ld_mask) && (ld_mask != 8'h00);
    assign partial_c = (fwd_covered != 8'h00) && !hit_c;

    logic        ld_v_q, ld_hit_q, ld_partial_q;
    logic [63:0] ld_data_q;

    // Result stage: register probe outcome for the following cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ld_v_q       <= 1'b0;
            ld_hit_q     <= 1'b0;
            ld_partial_q <= 1'b0;
            ld_data_q    <= '0;
        end else begin
            ld_v_q       <= ld_v_i;
            ld_hit_q     <= ld_v_i & hit_c;
            ld_partial_q <= ld_v_i & partial_c;
            ld_data_q    <= (ld_v_i && (fwd_en_p != 0)) ? fwd_data : 64'h0;
        end
    end

    assign ld_v_o       = ld_v_q;
    assign ld_hit_o     = ld_hit_q;
    assign ld_partial_o = ld_partial_q;
    assign ld_data_o    = ld_data_q;

`ifndef SYNTHESIS
    // Protocol checks: no drain of an empty queue, no misaligned stores
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(deq_yumi_i && empty));
            assert (!(enq_v_i && ((enq_paddr_i[2:0] & sq_align_mask(enq_size_i)) != 3'b000)));
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_pipe_mem_sq.sv
// Bench for the committed-store queue: directed scenarios plus a randomized
// run, all checked against a byte-address store model kept as a queue.
module tb_bp_be_pipe_mem_sq;

    localparam int ELS = 4;
    localparam int PW  = 40;
    localparam int CW  = $clog2(ELS) + 1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          enq_v_i, enq_ready_o;
    logic [PW-1:0] enq_paddr_i;
    logic [1:0]    enq_size_i;
    logic [63:0]   enq_data_i;
    logic          deq_v_o, deq_yumi_i;
    logic [PW-1:0] deq_paddr_o;
    logic [1:0]    deq_size_o;
    logic [63:0]   deq_data_o;
    logic          ld_v_i;
    logic [PW-1:0] ld_paddr_i;
    logic [1:0]    ld_size_i;
    logic          ld_v_o, ld_hit_o, ld_partial_o;
    logic [63:0]   ld_data_o;
    logic          empty_o;
    logic [CW-1:0] count_o;

    always #5 clk = ~clk;

    bp_be_pipe_mem_sq #(.els_p(ELS), .paddr_width_p(PW), .fwd_en_p(1)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .enq_v_i(enq_v_i), .enq_ready_o(enq_ready_o), .enq_paddr_i(enq_paddr_i),
        .enq_size_i(enq_size_i), .enq_data_i(enq_data_i),
        .deq_v_o(deq_v_o), .deq_yumi_i(deq_yumi_i), .deq_paddr_o(deq_paddr_o),
        .deq_size_o(deq_size_o), .deq_data_o(deq_data_o),
        .ld_v_i(ld_v_i), .ld_paddr_i(ld_paddr_i), .ld_size_i(ld_size_i),
        .ld_v_o(ld_v_o), .ld_hit_o(ld_hit_o), .ld_partial_o(ld_partial_o), .ld_data_o(ld_data_o),
        .empty_o(empty_o), .count_o(count_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: committed stores in program order, byte-addressed
    typedef struct {
        logic [PW-1:0] a;
        logic [1:0]    sz;
        logic [63:0]   d;
    } st_t;
    st_t q[$];

    logic        exp_ldv, exp_hit, exp_part;
    logic [63:0] exp_data;

    function automatic logic [63:0] trunc(input logic [63:0] d, input logic [1:0] sz);
        int nb;
        nb = 1 << sz;
        return (nb == 8) ? d : (d & ((64'd1 << (8 * nb)) - 64'd1));
    endfunction

    // For each requested byte address find the youngest store that wrote it
    task automatic probe_model(input logic [PW-1:0] la, input logic [1:0] lsz);
        logic [7:0]    want, cov;
        logic [PW-1:0] base, ba;
        int            nb;
        want = '0; cov = '0; exp_data = '0;
        base = {la[PW-1:3], 3'b000};
        nb   = 1 << lsz;
        for (int b = 0; b < 8; b++) begin
            if (b >= int'(la[2:0]) && b < int'(la[2:0]) + nb) begin
                want[b] = 1'b1;
                ba = base + PW'(b);
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (ba >= q[i].a && ba < q[i].a + PW'(1 << q[i].sz)) begin
                        cov[b] = 1'b1;
                        exp_data[8*b +: 8] = 8'(q[i].d >> (8 * int'(ba - q[i].a)));
                        break;
                    end
                end
            end
        end
        exp_hit  = (cov == want);
        exp_part = (cov != 8'h00) && !exp_hit;
    endtask

    // One clock: drive at negedge, advance model at posedge, leave at posedge+1
    task automatic step(input logic ev, input logic [PW-1:0] ea, input logic [1:0] esz,
                        input logic [63:0] ed, input logic y,
                        input logic lv, input logic [PW-1:0] la, input logic [1:0] lsz);
        int pre;
        @(negedge clk);
        enq_v_i = ev; enq_paddr_i = ea; enq_size_i = esz; enq_data_i = ed;
        deq_yumi_i = y; ld_v_i = lv; ld_paddr_i = la; ld_size_i = lsz;
        exp_ldv = lv;
        if (lv) probe_model(la, lsz);
        else begin exp_hit = 0; exp_part = 0; exp_data = '0; end
        pre = q.size();
        @(posedge clk);
        if (y && pre > 0) void'(q.pop_front());
        if (ev && pre < ELS) q.push_back('{a: ea, sz: esz, d: trunc(ed, esz)});
        #1;
        enq_v_i = 0; deq_yumi_i = 0; ld_v_i = 0;
    endtask

    task automatic idle();
        step(0, '0, 0, '0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1; enq_v_i = 0; deq_yumi_i = 0; ld_v_i = 0;
        @(posedge clk); #1;
        reset_i = 0;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty_o); end
        checks++; if (count_o !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
        checks++; if (deq_v_o !== 1'b0) begin errors++; $display("FAIL reset_deq_v got %0b want 0", deq_v_o); end
        checks++; if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", enq_ready_o); end
        checks++; if ({ld_v_o, ld_hit_o, ld_partial_o} !== 3'b000 || ld_data_o !== 64'h0) begin
            errors++; $display("FAIL reset_ld got v%0b h%0b p%0b d%h want all 0", ld_v_o, ld_hit_o, ld_partial_o, ld_data_o); end
    endtask

    task automatic test_sd_forward();
        step(1, 40'h80, 3, 64'h1122334455667788, 0, 0, '0, 0);
        checks++; if (deq_v_o !== 1'b1 || count_o !== CW'(1)) begin
            errors++; $display("FAIL sd_deq_latency got v%0b c%0d want v1 c1", deq_v_o, count_o); end
        step(0, '0, 0, '0, 0, 1, 40'h80, 3);
        checks++; if (ld_v_o !== 1'b1 || ld_hit_o !== 1'b1 || ld_partial_o !== 1'b0 || ld_data_o !== 64'h1122334455667788) begin
            errors++; $display("FAIL sd_fwd got v%0b h%0b p%0b d%h want hit d1122334455667788", ld_v_o, ld_hit_o, ld_partial_o, ld_data_o); end
        checks++; if (deq_paddr_o !== 40'h80 || deq_size_o !== 2'd3 || deq_data_o !== 64'h1122334455667788) begin
            errors++; $display("FAIL sd_deq got a%h s%0d d%h", deq_paddr_o, deq_size_o, deq_data_o); end
        step(0, '0, 0, '0, 1, 0, '0, 0);
        checks++; if (empty_o !== 1'b1 || deq_v_o !== 1'b0) begin
            errors++; $display("FAIL sd_drain got e%0b v%0b want e1 v0", empty_o, deq_v_o); end
    endtask

    task automatic test_youngest_wins();
        step(1, 40'h100, 2, 64'hAAAAAAAA, 0, 0, '0, 0);
        step(1, 40'h101, 0, 64'h55, 0, 0, '0, 0);
        step(0, '0, 0, '0, 0, 1, 40'h100, 2);
        checks++; if (ld_hit_o !== 1'b1 || ld_data_o !== 64'h00000000AAAA55AA || ld_data_o !== exp_data) begin
            errors++; $display("FAIL youngest got h%0b d%h want h1 d00000000aaaa55aa", ld_hit_o, ld_data_o); end
        // Head is the word store; the byte store follows with its own address
        checks++; if (deq_paddr_o !== 40'h100 || deq_data_o !== 64'hAAAAAAAA) begin
            errors++; $display("FAIL youngest_head got a%h d%h", deq_paddr_o, deq_data_o); end
        step(0, '0, 0, '0, 1, 0, '0, 0);
        checks++; if (deq_paddr_o !== 40'h101 || deq_size_o !== 2'd0 || deq_data_o !== 64'h55) begin
            errors++; $display("FAIL byte_head got a%h s%0d d%h want a101 s0 d55", deq_paddr_o, deq_size_o, deq_data_o); end
        step(0, '0, 0, '0, 1, 0, '0, 0);
    endtask

    task automatic test_partial();
        step(1, 40'h200, 0, 64'h7F, 0, 0, '0, 0);
        step(0, '0, 0, '0, 0, 1, 40'h200, 3);
        checks++; if (ld_partial_o !== 1'b1 || ld_hit_o !== 1'b0 || ld_data_o !== 64'h7F) begin
            errors++; $display("FAIL partial got h%0b p%0b d%h want h0 p1 d7f", ld_hit_o, ld_partial_o, ld_data_o); end
        step(0, '0, 0, '0, 0, 1, 40'h208, 3);
        checks++; if (ld_v_o !== 1'b1 || ld_partial_o !== 1'b0 || ld_hit_o !== 1'b0 || ld_data_o !== 64'h0) begin
            errors++; $display("FAIL no_overlap got v%0b h%0b p%0b d%h", ld_v_o, ld_hit_o, ld_partial_o, ld_data_o); end
        step(0, '0, 0, '0, 1, 0, '0, 0);
    endtask

    task automatic test_full_wrap();
        logic [PW-1:0] a;
        logic [63:0]   d;
        logic          ev, y;
        for (int i = 0; i < ELS; i++) step(1, PW'(40'h300 + 8 * i), 3, {$urandom, $urandom}, 0, 0, '0, 0);
        checks++; if (enq_ready_o !== 1'b0 || count_o !== CW'(ELS)) begin
            errors++; $display("FAIL full got r%0b c%0d want r0 c%0d", enq_ready_o, count_o, ELS); end
        step(1, 40'h340, 3, 64'hDEAD, 1, 0, '0, 0);
        checks++; if (count_o !== CW'(3) || deq_paddr_o !== 40'h308 || q.size() != 3) begin
            errors++; $display("FAIL full_no_bypass got c%0d a%h want c3 a308", count_o, deq_paddr_o); end
        for (int c = 0; c < 10; c++) begin
            ev = 1'($urandom); y = 1'($urandom) && (q.size() > 0);
            a = PW'(40'h400 + 8 * c); d = {$urandom, $urandom};
            step(ev, a, 3, d, y, 0, '0, 0);
            checks++; if (count_o !== CW'(q.size()) || (q.size() > 0 && (deq_paddr_o !== q[0].a || deq_data_o !== q[0].d))) begin
                errors++; $display("FAIL wrap_order cyc %0d got c%0d a%h d%h want c%0d", c, count_o, deq_paddr_o, deq_data_o, q.size()); end
        end
        while (q.size() > 0) step(0, '0, 0, '0, 1, 0, '0, 0);
    endtask

    task automatic test_same_cycle();
        step(1, 40'h500, 3, 64'hCAFEF00D12345678, 0, 1, 40'h500, 3);
        checks++; if (ld_v_o !== 1'b1 || ld_hit_o !== 1'b0 || ld_partial_o !== 1'b0) begin
            errors++; $display("FAIL same_cycle_enq got v%0b h%0b p%0b want v1 h0 p0", ld_v_o, ld_hit_o, ld_partial_o); end
        step(0, '0, 0, '0, 1, 1, 40'h504, 2);
        checks++; if (ld_hit_o !== 1'b1 || ld_data_o !== 64'hCAFEF00D00000000 || empty_o !== 1'b1) begin
            errors++; $display("FAIL same_cycle_deq got h%0b d%h e%0b want h1 dcafef00d00000000 e1", ld_hit_o, ld_data_o, empty_o); end
        step(1, 40'h600, 3, 64'h1, 0, 0, '0, 0);
        step(1, 40'h608, 3, 64'h2, 0, 0, '0, 0);
        do_reset();
        checks++; if (empty_o !== 1'b1 || count_o !== '0 || deq_v_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset got e%0b c%0d v%0b want e1 c0 v0", empty_o, count_o, deq_v_o); end
    endtask

    task automatic test_random();
        logic          ev, y, lv;
        logic [1:0]    esz, lsz;
        logic [PW-1:0] ea, la;
        logic [63:0]   ed;
        for (int c = 0; c < 300; c++) begin
            ev  = ($urandom_range(0, 3) != 0);
            y   = ($urandom_range(0, 2) == 0) && (q.size() > 0);
            lv  = 1'($urandom);
            esz = 2'($urandom);
            lsz = 2'($urandom);
            ea  = PW'(40'h1000 + 8 * $urandom_range(0, 2)) + PW'($urandom_range(0, 7) & ~((1 << esz) - 1));
            la  = PW'(40'h1000 + 8 * $urandom_range(0, 3)) + PW'($urandom_range(0, 7) & ~((1 << lsz) - 1));
            ed  = trunc({$urandom, $urandom}, esz);
            step(ev, ea, esz, ed, y, lv, la, lsz);
            checks++;
            if (ld_v_o !== exp_ldv || ld_hit_o !== exp_hit || ld_partial_o !== exp_part || ld_data_o !== exp_data) begin
                errors++; $display("FAIL rand_fwd cyc %0d got v%0b h%0b p%0b d%h want v%0b h%0b p%0b d%h",
                                   c, ld_v_o, ld_hit_o, ld_partial_o, ld_data_o, exp_ldv, exp_hit, exp_part, exp_data); end
            checks++;
            if (count_o !== CW'(q.size()) || empty_o !== (q.size() == 0) || enq_ready_o !== (q.size() < ELS)
                || (q.size() > 0 && (deq_paddr_o !== q[0].a || deq_size_o !== q[0].sz || deq_data_o !== q[0].d))) begin
                errors++; $display("FAIL rand_queue cyc %0d got c%0d e%0b r%0b a%h d%h want c%0d", c, count_o, empty_o,
                                   enq_ready_o, deq_paddr_o, deq_data_o, q.size()); end
        end
    endtask

    initial begin
        reset_i = 1; enq_v_i = 0; enq_paddr_i = '0; enq_size_i = 0; enq_data_i = '0;
        deq_yumi_i = 0; ld_v_i = 0; ld_paddr_i = '0; ld_size_i = 0;
        exp_ldv = 0; exp_hit = 0; exp_part = 0; exp_data = '0;
        test_reset();
        test_sd_forward();
        test_youngest_wins();
        test_partial();
        test_full_wrap();
        test_same_cycle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
